// File: rtl/wb_bfm_arbiter_if.sv
// Wishbone N-master / 1-slave bus bundle for wb_bfm_arbiter.
// "master" modport: the arbiter's view. It receives the master requests and
// drives the shared slave bus. "slave" modport: the view of the attached
// masters and slave, with every direction reversed.
interface wb_bfm_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int aw          = 32,
  parameter int dw          = 32
);
  // Master-side requests
  logic [NUM_MASTERS*aw-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*dw-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*dw/8-1:0]   wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [3*NUM_MASTERS-1:0]      wbm_cti_i;
  logic [2*NUM_MASTERS-1:0]      wbm_bte_i;
  // Master-side responses
  logic [dw-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;
  // Slave-side requests
  logic [aw-1:0]                 wbs_adr_o;
  logic [dw-1:0]                 wbs_dat_o;
  logic [dw/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  // Slave-side responses
  logic [dw-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  modport master (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport slave (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_bfm_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// The owner keeps the slave for its whole cyc assertion; the next owner is
// picked at the edge where the owner's cyc is sampled low, with no bubble.
// Optional strobe timeout answers the owner with a one-cycle error.
module wb_bfm_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  wb_bfm_arbiter_if.master       bus,
  output logic [NUM_MASTERS-1:0] grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = dw / 8;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [TW-1:0]          cnt_q, cnt_d;

  logic          owner_cyc, owner_stb, arb_edge, any_req;
  logic          timeout_hit, slave_resp;
  logic          found_hi, found_lo;
  logic [IW-1:0] win, win_hi, win_lo;

  // Owner's handshake, selected by the one-hot grant (zero in IDLE)
  always_comb begin
    owner_cyc   = |(grant_q & bus.wbm_cyc_i);
    owner_stb   = |(grant_q & bus.wbm_stb_i);
    arb_edge    = (state_q == IDLE) || !owner_cyc;
    slave_resp  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    timeout_hit = (TIMEOUT > 0) && (state_q == OWNED) && (cnt_q == TW'(TIMEOUT));
  end

  // Round-robin search: lowest requester above last wins, else lowest at or below last
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (bus.wbm_cyc_i[m]) begin
        if (m > 32'(last_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = IW'(m);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = IW'(m);
        end
      end
    end
    any_req = found_hi | found_lo;
    win     = found_hi ? win_hi : win_lo;
  end

  // Next state: arbitrate on arbitration edges, otherwise run the timeout counter
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = '0;
    if (arb_edge) begin
      if (any_req) begin
        state_d      = OWNED;
        last_d       = win;
        grant_d      = '0;
        grant_d[win] = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end else if ((TIMEOUT > 0) && owner_stb && !slave_resp && !timeout_hit) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // State registers; last resets to the top master so master 0 wins first
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;

  // Request mux from the owner's slice and response steering to the owner only.
  // The grant register is cleared asynchronously by reset, so gating on it also
  // forces the slave bus idle immediately.
  always_comb begin
    bus.wbm_dat_o = bus.wbs_dat_i;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (grant_q[m]) begin
        bus.wbs_adr_o    = bus.wbm_adr_i[m*aw +: aw];
        bus.wbs_dat_o    = bus.wbm_dat_i[m*dw +: dw];
        bus.wbs_sel_o    = bus.wbm_sel_i[m*SW +: SW];
        bus.wbs_we_o     = bus.wbm_we_i[m];
        bus.wbs_cyc_o    = bus.wbm_cyc_i[m];
        bus.wbs_stb_o    = bus.wbm_stb_i[m] & ~timeout_hit;
        bus.wbs_cti_o    = bus.wbm_cti_i[m*3 +: 3];
        bus.wbs_bte_o    = bus.wbm_bte_i[m*2 +: 2];
        bus.wbm_ack_o[m] = bus.wbs_ack_i & ~timeout_hit;
        bus.wbm_err_o[m] = (bus.wbs_err_i & ~timeout_hit) | timeout_hit;
        bus.wbm_rty_o[m] = bus.wbs_rty_i & ~timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_wb_bfm_arbiter.sv
// Directed bench for wb_bfm_arbiter: 3 masters, 32-bit bus, TIMEOUT=4.
module tb_wb_bfm_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] grant;
  int         total;
  int         bad;

  wb_bfm_arbiter_if #(.NUM_MASTERS(3), .aw(32), .dw(32)) bus ();

  wb_bfm_arbiter #(
    .NUM_MASTERS(3),
    .aw         (32),
    .dw         (32),
    .TIMEOUT    (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
    bus.wbm_cyc_i[m]         = c;
    bus.wbm_stb_i[m]         = s;
    bus.wbm_we_i[m]          = w;
    bus.wbm_adr_i[m*32 +: 32] = a;
    bus.wbm_dat_i[m*32 +: 32] = d;
    bus.wbm_sel_i[m*4 +: 4]   = sl;
    bus.wbm_cti_i[m*3 +: 3]   = ct;
    bus.wbm_bte_i[m*2 +: 2]   = bt;
  endtask

  task automatic drop(input int m);
    bus.wbm_cyc_i[m] = 1'b0;
    bus.wbm_stb_i[m] = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0;
    bus.wbm_we_i  = '0; bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = 1'b0; bus.wbs_err_i = 1'b0; bus.wbs_rty_i = 1'b0;

    // Reset held with all masters requesting and the slave answering
    set_m(0, 1, 1, 0, 32'h100, 32'hA0A0A0A0, 4'h1, 3'd0, 2'd0);
    set_m(1, 1, 1, 1, 32'h200, 32'hB1B1B1B1, 4'h3, 3'd2, 2'd1);
    set_m(2, 1, 1, 0, 32'h300, 32'hC2C2C2C2, 4'hF, 3'd7, 2'd2);
    bus.wbs_ack_i = 1'b1;
    bus.wbs_err_i = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_cyc",   bus.wbs_cyc_o, 1'b0);
    chk("rst_stb",   bus.wbs_stb_o, 1'b0);
    chk("rst_adr",   bus.wbs_adr_o, 32'h0);
    chk("rst_ack",   bus.wbm_ack_o, 3'b000);
    chk("rst_err",   bus.wbm_err_o, 3'b000);
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;

    // Release: no rising edge with rst_n high yet
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_grant", grant, 3'b000);

    // Round robin from reset: master 0 first
    @(negedge clk); #1;
    chk("rr0_grant", grant, 3'b001);
    chk("rr0_cyc",   bus.wbs_cyc_o, 1'b1);
    chk("rr0_adr",   bus.wbs_adr_o, 32'h100);
    chk("rr0_dat",   bus.wbs_dat_o, 32'hA0A0A0A0);
    chk("rr0_sel",   bus.wbs_sel_o, 4'h1);
    chk("rr0_we",    bus.wbs_we_o, 1'b0);
    // Owner drops cyc together with the ack: ack still reaches it
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'h12345678;
    drop(0);
    #1;
    chk("rr0_ack",   bus.wbm_ack_o, 3'b001);
    chk("rr0_rdat",  bus.wbm_dat_o, 32'h12345678);
    chk("rr0_dcyc",  bus.wbs_cyc_o, 1'b0);

    @(negedge clk); bus.wbs_ack_i = 1'b0; #1;
    chk("rr1_grant", grant, 3'b010);
    chk("rr1_adr",   bus.wbs_adr_o, 32'h200);
    chk("rr1_we",    bus.wbs_we_o, 1'b1);
    chk("rr1_sel",   bus.wbs_sel_o, 4'h3);
    chk("rr1_bte",   bus.wbs_bte_o, 2'd1);
    chk("rr1_noack", bus.wbm_ack_o, 3'b000);
    bus.wbs_rty_i = 1'b1; #1;
    chk("rr1_rty",   bus.wbm_rty_o, 3'b010);

    @(negedge clk); bus.wbs_rty_i = 1'b0; bus.wbs_ack_i = 1'b1; drop(1); #1;
    chk("rr1_hold",  grant, 3'b010);
    chk("rr1_ack",   bus.wbm_ack_o, 3'b010);

    @(negedge clk); bus.wbs_ack_i = 1'b0; #1;
    chk("rr2_grant", grant, 3'b100);
    chk("rr2_adr",   bus.wbs_adr_o, 32'h300);
    chk("rr2_cti",   bus.wbs_cti_o, 3'd7);
    chk("rr2_bte",   bus.wbs_bte_o, 2'd2);
    bus.wbs_err_i = 1'b1; drop(2); #1;
    chk("rr2_err",   bus.wbm_err_o, 3'b100);
    chk("rr2_noack", bus.wbm_ack_o, 3'b000);

    @(negedge clk); bus.wbs_err_i = 1'b0; #1;
    chk("idle_grant", grant, 3'b000);
    chk("idle_cyc",   bus.wbs_cyc_o, 1'b0);
    chk("idle_adr",   bus.wbs_adr_o, 32'h0);
    chk("idle_err",   bus.wbm_err_o, 3'b000);

    // 8-beat incrementing burst by master 1 while master 0 waits
    set_m(1, 1, 1, 0, 32'h400, 32'hB1B1B1B1, 4'hF, 3'd2, 2'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wbm_cti_i[5:3] = (i == 7) ? 3'd7 : 3'd2;
      if (i == 0) set_m(0, 1, 1, 0, 32'h500, 32'hA0A0A0A0, 4'h1, 3'd0, 2'd0);
      bus.wbs_ack_i = 1'b1;
      #1;
      chk("bst_grant", grant, 3'b010);
      chk("bst_ack",   bus.wbm_ack_o, 3'b010);
      chk("bst_cti",   bus.wbs_cti_o, (i == 7) ? 3'd7 : 3'd2);
    end
    @(negedge clk); bus.wbs_ack_i = 1'b0; drop(1); #1;
    chk("bst_end_grant", grant, 3'b010);
    chk("bst_end_cyc",   bus.wbs_cyc_o, 1'b0);
    @(negedge clk); #1;
    chk("hand_grant", grant, 3'b001);
    chk("hand_cyc",   bus.wbs_cyc_o, 1'b1);
    chk("hand_adr",   bus.wbs_adr_o, 32'h500);
    drop(0);
    @(negedge clk); #1;
    chk("bst_idle", grant, 3'b000);

    // Timeout: slave never answers master 2
    set_m(2, 1, 1, 0, 32'h600, 32'hC2C2C2C2, 4'hF, 3'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) bus.wbs_ack_i = 1'b1;
      #1;
      chk("to_grant", grant, 3'b100);
      chk("to_err",   bus.wbm_err_o, (i == 4) ? 3'b100 : 3'b000);
      chk("to_stb",   bus.wbs_stb_o, (i == 4) ? 1'b0 : 1'b1);
      if (i == 4) chk("to_ackdrop", bus.wbm_ack_o, 3'b000);
    end
    @(negedge clk); bus.wbs_ack_i = 1'b0; #1;
    chk("to_clr_err", bus.wbm_err_o, 3'b000);
    chk("to_clr_stb", bus.wbs_stb_o, 1'b1);
    drop(2);
    @(negedge clk); #1;
    chk("to_idle", grant, 3'b000);

    // Asynchronous reset in the middle of a master 1 burst
    set_m(1, 1, 1, 0, 32'h700, 32'hB1B1B1B1, 4'hF, 3'd2, 2'd0);
    @(negedge clk); #1;
    chk("ar_grant", grant, 3'b010);
    chk("ar_cyc",   bus.wbs_cyc_o, 1'b1);
    #2;
    set_m(0, 1, 1, 0, 32'h100, 32'hA0A0A0A0, 4'h1, 3'd0, 2'd0);
    set_m(2, 1, 1, 0, 32'h300, 32'hC2C2C2C2, 4'hF, 3'd0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_now_grant", grant, 3'b000);
    chk("ar_now_cyc",   bus.wbs_cyc_o, 1'b0);
    chk("ar_now_stb",   bus.wbs_stb_o, 1'b0);
    @(negedge clk); #1;
    chk("ar_hold_grant", grant, 3'b000);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ar_rel_grant", grant, 3'b001);
    drop(0); drop(1); drop(2);
    @(negedge clk); #1;
    chk("ar_idle", grant, 3'b000);

    // One master, back-to-back cycles separated by one low-cyc cycle
    for (int k = 0; k < 3; k++) begin
      set_m(2, 1, 1, 1, 32'h800 + 32'(k), 32'hC2C2C2C2, 4'hF, 3'd0, 2'd0);
      @(negedge clk); #1;
      chk("b2b_grant", grant, 3'b100);
      bus.wbs_ack_i = 1'b1; #1;
      chk("b2b_ack", bus.wbm_ack_o, 3'b100);
      @(negedge clk); bus.wbs_ack_i = 1'b0; drop(2); #1;
      chk("b2b_low_cyc", bus.wbs_cyc_o, 1'b0);
      @(negedge clk); #1;
      chk("b2b_idle", grant, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
